pack: RTL and testbench
=======================

// Module: pack
// PURPOSE
//   Serial-to-parallel converter, the inverse of unpack: collects D consecutive W-bit words from a
//   valid/ready stream and emits them as one packed D*W-bit word on a valid/ready stream.
//   Sits wherever narrow per-element streams feed vector-wide consumers.
//   Sustains one input word per cycle when the consumer keeps up.
// PARAMETERS
//   W  8  width of one element in bits (>= 1)
//   D  4  elements per packed output word (>= 1)
// PORTS
//   clk      in   1       clock; all state on rising edge
//   rst      in   1       asynchronous, active-low reset
//   s_data   in   W       input element
//   s_valid  in   1       input element valid
//   s_ready  out  1       block accepts s_data this cycle
//   m_data   out  [D-1:0][W-1:0]  packed output; element 0 = first word received
//   m_valid  out  1       packed word valid
//   m_ready  in   1       consumer accepts m_data this cycle
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst is asynchronous and active-low.
//   - Handshake: transfer occurs when valid && ready on the same rising edge. m_valid and m_data
//     hold stable until accepted. s_ready never depends combinationally on s_valid.
//   - Reset (rst low, async): m_valid=0, element count=0, s_ready=0 while asserted.
//     m_data is reset to 0. Partial accumulations are discarded.
//     After rst deasserts, s_ready=1 from the first edge.
//   - State: accumulator acc[D-2:0][W-1:0], count cnt in 0..D-1, output register out[D-1:0][W-1:0],
//     flag m_valid. cnt width = max(1, $clog2(D)).
//   - Accept (s_valid && s_ready), cnt < D-1: acc[cnt] <= s_data; cnt <= cnt+1.
//   - Accept, cnt == D-1 (final element): out <= {s_data, acc[D-2:0]}; m_valid <= 1; cnt <= 0.
//     No extra latency: m_valid rises on the edge that takes the D-th element.
//   - Output drain: m_valid && m_ready && !(final accept this edge) -> m_valid <= 0.
//     Final accept coincident with drain -> m_valid stays 1 with the new word (back-to-back).
//   - s_ready = rst && (cnt != D-1 || !m_valid || m_ready).
//     Elements 0..D-2 are accepted even while out is held. Only the completing element stalls.
//   - Throughput: D elements per D cycles, with no bubbles, when m_ready is held high.
//   - Backpressure: with m_ready low and m_valid=1, exactly D-1 further elements are accepted.
//     s_ready then drops until the output is drained. No element is lost or duplicated.
//   - cnt wraps D-1 -> 0 only on the final accept. It never advances without a transfer.
//   - D == 1: acc is absent, every accept is final, and the block behaves as a single-stage
//     register slice.
//   - Reset mid-word: partial data is dropped; the first element after reset is element 0.
// STRUCTURE
//   - Single module, no sub-module. The counter and muxing are too small to warrant one.
//   - Shared package: none required. Width localparams (CW) are derived locally from W, D.
//   - Packed type [D-1:0][W-1:0] matches unpack's input, so pack->unpack round-trips directly.
// TESTING  (W=8, D=4 unless stated)
//   1 Basic: send 8'h11,22,33,44 with m_ready=1.
//     -> m_data=32'h44332211, m_valid on the edge accepting 8'h44.
//   2 Streaming: 16 random words, s_valid and m_ready held 1.
//     -> 4 outputs, one every 4 cycles, s_ready never low, data in order.
//   3 Backpressure: m_ready=0 after first word completes; push 8 words.
//     -> s_ready drops after the 7th word. Raising m_ready gives 1st word out.
//     -> The 8th word is accepted the same cycle; the 2nd word follows 1 cycle later.
//   4 Random valid/ready: 1000 words, 50% random s_valid and m_ready.
//     -> Scoreboard match, stable m_data while m_valid && !m_ready.
//   5 Reset mid-word: accept 8'hAA,8'hBB, pull rst low for 2 cycles, then send 8'h01..04.
//     -> m_valid=0 during reset, single output 32'h04030201.
//   6 D=1, W=8: words 8'h5A,8'hA5 back-to-back with m_ready=1.
//     -> Outputs 8'h5A then 8'hA5 on consecutive cycles.
//   - Round-trip: pack feeding unpack returns the original sequence.
//   - Testbench timeout of 1e6 cycles.

Source files
------------

// File: rtl/pack_pkg.sv
// Shared defaults and width helpers for the serial-to-parallel packer.
package pack_pkg;

   localparam int DEF_W = 8;
   localparam int DEF_D = 4;

   // Counter width; a single-element word still keeps a 1-bit counter.
   function automatic int cnt_width(input int d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

endpackage

// File: rtl/pack_if.sv
// Element-in / packed-word-out valid/ready stream pair seen by the packer.
interface pack_if
   import pack_pkg::*;
#(
   parameter int W = DEF_W,
   parameter int D = DEF_D
);

   logic [W-1:0]        s_data;
   logic                s_valid;
   logic                s_ready;
   logic [D-1:0][W-1:0] m_data;
   logic                m_valid;
   logic                m_ready;

   modport master (
      output s_data, s_valid, m_ready,
      input  s_ready, m_data, m_valid
   );

   modport slave (
      input  s_data, s_valid, m_ready,
      output s_ready, m_data, m_valid
   );

endinterface

// File: rtl/pack.sv
// Packs D consecutive W-bit elements into one word; m_valid rises on the edge taking element D-1.
// Backpressure: only the completing element stalls while a packed word is still held.
module pack
   import pack_pkg::*;
#(
   parameter int W = DEF_W,
   parameter int D = DEF_D
) (
   input  logic  clk,
   input  logic  rst,
   pack_if.slave bus
);

   localparam int            CW   = cnt_width(D);
   localparam logic [CW-1:0] LAST = CW'(D - 1);

   logic [CW-1:0]       cnt;
   logic                m_valid_q;
   logic [D-1:0][W-1:0] out_q;
   logic                room;
   logic                accept;
   logic                final_acc;

   // The only element that needs a free output register is the last one of a word.
   assign room        = (cnt != LAST) || !m_valid_q || bus.m_ready;
   assign bus.s_ready = rst && room;
   assign accept      = bus.s_valid && bus.s_ready;
   assign final_acc   = accept && (cnt == LAST);

   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = out_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         m_valid_q <= 1'b0;
      end else if (final_acc) begin
         cnt       <= '0;
         m_valid_q <= 1'b1;
      end else begin
         if (accept) begin
            cnt <= cnt + CW'(1);
         end
         if (m_valid_q && bus.m_ready) begin
            m_valid_q <= 1'b0;
         end
      end
   end

   generate
      if (D == 1) begin : g_slice
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               out_q <= '0;
            end else if (final_acc) begin
               out_q <= bus.s_data;
            end
         end
      end else begin : g_acc
         logic [D-2:0][W-1:0] acc;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               acc   <= '0;
               out_q <= '0;
            end else begin
               if (accept && !final_acc) begin
                  for (int i = 0; i < D - 1; i++) begin
                     if (cnt == CW'(i)) begin
                        acc[i] <= bus.s_data;
                     end
                  end
               end
               if (final_acc) begin
                  out_q <= {bus.s_data, acc};
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_pack.sv
// Directed and randomized bench for pack (D=4 and D=1 instances) with a queue-based reference model.
module tb_pack;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pack_if #(.W(8), .D(4)) b4 ();
   pack_if #(.W(8), .D(1)) b1 ();

   pack #(.W(8), .D(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
   pack #(.W(8), .D(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   logic [7:0]  inq[$];
   logic [31:0] expq[$];
   int          tq[$];
   bit          s_fire;
   bit          m_fire;
   bit          hold;
   logic [31:0] held;
   int          sready_low;
   int          out_count;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle on the D=4 instance: drive at negedge, score the transfers the next posedge will make.
   task automatic cyc(input bit sv, input logic [7:0] sd, input bit mr);
      logic [31:0] e;
      @(negedge clk);
      b4.s_valid = sv;
      b4.s_data  = sd;
      b4.m_ready = mr;
      #1;
      if (hold) begin
         check("hold_valid", 32'(b4.m_valid), 32'd1);
         check("hold_data", b4.m_data, held);
      end
      s_fire = sv && b4.s_ready;
      m_fire = b4.m_valid && mr;
      if (!b4.s_ready) sready_low++;
      if (m_fire) begin
         out_count++;
         check("out_pending", 32'(expq.size() != 0), 32'd1);
         if (expq.size() != 0) begin
            e = expq.pop_front();
            check("out_data", b4.m_data, e);
         end
      end
      hold = b4.m_valid && !mr;
      held = b4.m_data;
      if (s_fire) begin
         inq.push_back(sd);
         if (inq.size() == 4) begin
            expq.push_back({inq[3], inq[2], inq[1], inq[0]});
            inq.delete();
         end
      end
   endtask

   initial begin
      repeat (1000000) @(posedge clk);
      $display("FAIL timeout: run exceeded 1000000 cycles");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] w3[8];
      int idx;
      int sent;
      int n;

      rst = 1'b0;
      hold = 1'b0;
      b4.s_valid = 1'b0; b4.s_data = '0; b4.m_ready = 1'b0;
      b1.s_valid = 1'b0; b1.s_data = '0; b1.m_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_s_ready", 32'(b4.s_ready), 32'd0);
      check("rst_m_valid", 32'(b4.m_valid), 32'd0);
      check("rst_m_data", b4.m_data, 32'd0);
      check("rst_m_valid_d1", 32'(b1.m_valid), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("s_ready_after_rst", 32'(b4.s_ready), 32'd1);

      // Basic packing
      cyc(1'b1, 8'h11, 1'b1);
      cyc(1'b1, 8'h22, 1'b1);
      cyc(1'b1, 8'h33, 1'b1);
      check("t1_no_early_valid", 32'(b4.m_valid), 32'd0);
      cyc(1'b1, 8'h44, 1'b1);
      @(posedge clk);
      #1;
      check("t1_valid", 32'(b4.m_valid), 32'd1);
      check("t1_data", b4.m_data, 32'h44332211);
      cyc(1'b0, 8'h00, 1'b1);

      // Streaming at full rate
      out_count = 0;
      sready_low = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 8'($urandom), 1'b1);
         if (m_fire) tq.push_back(i);
      end
      cyc(1'b0, 8'h00, 1'b1);
      if (m_fire) tq.push_back(16);
      check("t2_outputs", 32'(out_count), 32'd4);
      check("t2_sready_low", 32'(sready_low), 32'd0);
      check("t2_first_out", 32'(tq.size() > 0 ? tq[0] : -1), 32'd4);
      for (int k = 1; k < tq.size(); k++) begin
         check("t2_gap", 32'(tq[k] - tq[k-1]), 32'd4);
      end

      // Backpressure: 7 accepted, 8th waits for the drain
      for (int i = 0; i < 8; i++) w3[i] = 8'($urandom);
      idx = 0;
      sready_low = 0;
      for (int c = 0; c < 10; c++) begin
         cyc(1'b1, w3[idx < 8 ? idx : 7], 1'b0);
         if (s_fire) idx++;
      end
      check("t3_accepted", 32'(idx), 32'd7);
      check("t3_sready_low", 32'(sready_low), 32'd3);
      cyc(1'b1, w3[7], 1'b1);
      check("t3_final_with_drain_s", 32'(s_fire), 32'd1);
      check("t3_final_with_drain_m", 32'(m_fire), 32'd1);
      cyc(1'b0, 8'h00, 1'b1);
      check("t3_second_next_cycle", 32'(m_fire), 32'd1);

      // Random valid/ready traffic
      sent = 0;
      n = 0;
      while (sent < 1000 && n < 20000) begin
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
         if (s_fire) sent++;
         n++;
      end
      check("t4_sent", 32'(sent), 32'd1000);
      n = 0;
      while (expq.size() > 0 && n < 100) begin
         cyc(1'b0, 8'h00, 1'b1);
         n++;
      end
      check("t4_drained", 32'(expq.size()), 32'd0);
      check("t4_no_partial", 32'(inq.size()), 32'd0);

      // Reset in the middle of a word
      out_count = 0;
      cyc(1'b1, 8'hAA, 1'b1);
      cyc(1'b1, 8'hBB, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      b4.s_valid = 1'b0;
      #1;
      inq.delete();
      expq.delete();
      hold = 1'b0;
      check("t5_rst_m_valid", 32'(b4.m_valid), 32'd0);
      check("t5_rst_s_ready", 32'(b4.s_ready), 32'd0);
      @(negedge clk);
      #1;
      check("t5_rst_m_valid2", 32'(b4.m_valid), 32'd0);
      check("t5_rst_m_data", b4.m_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      cyc(1'b1, 8'h01, 1'b1);
      cyc(1'b1, 8'h02, 1'b1);
      cyc(1'b1, 8'h03, 1'b1);
      cyc(1'b1, 8'h04, 1'b1);
      @(posedge clk);
      #1;
      check("t5_word", b4.m_data, 32'h04030201);
      cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b1);
      check("t5_outputs", 32'(out_count), 32'd1);

      // D=1 register slice
      @(negedge clk);
      b1.s_valid = 1'b1;
      b1.s_data  = 8'h5A;
      b1.m_ready = 1'b1;
      #1;
      check("t6_s_ready", 32'(b1.s_ready), 32'd1);
      @(negedge clk);
      b1.s_data = 8'hA5;
      #1;
      check("t6_valid0", 32'(b1.m_valid), 32'd1);
      check("t6_data0", 32'(b1.m_data), 32'h5A);
      check("t6_s_ready_full", 32'(b1.s_ready), 32'd1);
      @(negedge clk);
      b1.s_valid = 1'b0;
      #1;
      check("t6_valid1", 32'(b1.m_valid), 32'd1);
      check("t6_data1", 32'(b1.m_data), 32'hA5);
      @(negedge clk);
      #1;
      check("t6_idle", 32'(b1.m_valid), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
